// File: rtl/rf_recovery_ctrl.sv
// Lockstep register-file recovery: golden shadow copy, halt, replay, release.
// Optional FT_ERR_CNT_EN adds a saturating mismatch counter on err_count_o.
module rf_recovery_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmp_we_i,
  input  logic [ADDR_WIDTH-1:0] cmp_addr_i,
  input  logic [DATA_WIDTH-1:0] cmp_data_i,
  input  logic                  cmp_error_i,
  input  logic                  halt_ack_i,
  output logic                  halt_o,
  output logic                  recover_we_o,
  output logic [ADDR_WIDTH-1:0] recover_addr_o,
  output logic [DATA_WIDTH-1:0] recover_data_o,
  output logic                  recover_done_o
`ifdef FT_ERR_CNT_EN
  ,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    HALT,
    RESTORE,
    DONE
  } state_t;

  state_t state;

  // Entry 0 is architecturally zero, so it has no storage.
  logic [DATA_WIDTH-1:0] shadow [1:DEPTH-1];

  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic                  shadow_we;

  assign nxt_addr  = (state == HALT) ? ADDR_WIDTH'(1)
                                     : recover_addr_o + 1'b1;
  assign shadow_we = (state == IDLE) && cmp_we_i && !cmp_error_i
                     && (cmp_addr_i != '0);

  always_comb begin
    nxt_data = '0;
    if (nxt_addr != '0) nxt_data = shadow[nxt_addr];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < DEPTH; i++) shadow[i] <= '0;
    end else if (shadow_we) begin
      shadow[cmp_addr_i] <= cmp_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      halt_o         <= 1'b0;
      recover_we_o   <= 1'b0;
      recover_addr_o <= '0;
      recover_data_o <= '0;
      recover_done_o <= 1'b0;
    end else begin
      recover_done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmp_error_i) begin
            state  <= HALT;
            halt_o <= 1'b1;
          end
        end
        HALT: begin
          if (halt_ack_i) begin
            state          <= RESTORE;
            recover_we_o   <= 1'b1;
            recover_addr_o <= nxt_addr;
            recover_data_o <= nxt_data;
          end
        end
        RESTORE: begin
          if (&recover_addr_o) begin
            state          <= DONE;
            recover_we_o   <= 1'b0;
            recover_addr_o <= '0;
            recover_data_o <= '0;
            recover_done_o <= 1'b1;
          end else begin
            recover_addr_o <= nxt_addr;
            recover_data_o <= nxt_data;
          end
        end
        DONE: begin
          state  <= IDLE;
          halt_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef FT_ERR_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_count_o <= '0;
    end else if (state == IDLE && cmp_error_i && !(&err_count_o)) begin
      err_count_o <= err_count_o + 1'b1;
    end
  end
`else
  if (ERR_CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("ERR_CNT_WIDTH must be at least 1");
  end
`endif

endmodule

// File: tb/tb_rf_recovery_ctrl.sv
// Scoreboard bench for rf_recovery_ctrl: model shadow, expected replay queue.
// Define FT_ERR_CNT_EN to also check the saturating mismatch counter.
module tb_rf_recovery_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmp_we_i;
  logic [4:0]  cmp_addr_i;
  logic [31:0] cmp_data_i;
  logic        cmp_error_i;
  logic        halt_ack_i;
  logic        halt_o;
  logic        recover_we_o;
  logic [4:0]  recover_addr_o;
  logic [31:0] recover_data_o;
  logic        recover_done_o;
`ifdef FT_ERR_CNT_EN
  logic [1:0]  err_count_o;
`endif

  rf_recovery_ctrl #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (5),
    .ERR_CNT_WIDTH(2)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cmp_we_i      (cmp_we_i),
    .cmp_addr_i    (cmp_addr_i),
    .cmp_data_i    (cmp_data_i),
    .cmp_error_i   (cmp_error_i),
    .halt_ack_i    (halt_ack_i),
    .halt_o        (halt_o),
    .recover_we_o  (recover_we_o),
    .recover_addr_o(recover_addr_o),
    .recover_data_o(recover_data_o),
    .recover_done_o(recover_done_o)
`ifdef FT_ERR_CNT_EN
    ,
    .err_count_o   (err_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m[32];
  logic [1:0]  exp_cnt;
  int          n_vec;
  int          n_err;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (recover_we_o) begin
        if (q.size() == 0) begin
          check("wr_unexpected", 64'(q.size()), 64'd1);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("wr_addr", 64'(recover_addr_o), 64'(e.a));
          check("wr_data", 64'(recover_data_o), 64'(e.d));
        end
      end else begin
        check("idle_bus", {27'd0, recover_addr_o, recover_data_o}, 64'd0);
      end
    end
  end

  task automatic agreed_wr(input logic [4:0] a, input logic [31:0] d);
    cmp_we_i   = 1'b1;
    cmp_addr_i = a;
    cmp_data_i = d;
    tick();
    cmp_we_i = 1'b0;
    if (a != 5'd0) m[a] = d;
  endtask

  task automatic run_recovery(input int ack_dly, input bit sneak,
                              input bit noisy, input bit abort);
    cmp_error_i = 1'b1;
    if (sneak) begin
      cmp_we_i   = 1'b1;
      cmp_addr_i = 5'd7;
      cmp_data_i = 32'hAAAA5555;
    end
    for (int i = 1; i < 32; i++) q.push_back('{a: 5'(i), d: m[i]});
    tick();
    cmp_error_i = 1'b0;
    cmp_we_i    = 1'b0;
    if (exp_cnt != 2'b11) exp_cnt++;
    check("halt_rise", 64'(halt_o), 64'd1);
`ifdef FT_ERR_CNT_EN
    check("err_count", 64'(err_count_o), 64'(exp_cnt));
`endif
    for (int i = 0; i < ack_dly; i++) begin
      if (noisy) begin
        cmp_error_i = 1'($urandom_range(1));
        cmp_we_i    = 1'b1;
        cmp_addr_i  = 5'd9;
        cmp_data_i  = $urandom;
      end
      tick();
      check("halt_hold", 64'(halt_o), 64'd1);
      check("halt_no_wr", 64'(recover_we_o), 64'd0);
    end
    cmp_error_i = 1'b0;
    cmp_we_i    = 1'b0;
    halt_ack_i  = 1'b1;
    tick();
    check("first_wr", {recover_we_o, recover_addr_o}, {1'b1, 5'd1});
    halt_ack_i = 1'b0;
    if (abort) begin
      repeat (9) tick();
      check("abort_idx", 64'(recover_addr_o), 64'd10);
      rst_ni = 1'b0;
      #1;
      check("abort_out", {halt_o, recover_we_o, recover_addr_o,
                          recover_data_o, recover_done_o}, 64'd0);
      q.delete();
      for (int i = 0; i < 32; i++) m[i] = '0;
      exp_cnt = '0;
      repeat (2) begin
        tick();
        check("abort_hold", {halt_o, recover_we_o}, 64'd0);
      end
      rst_ni = 1'b1;
      tick();
    end else begin
      repeat (31) tick();
      check("done_pulse", {recover_done_o, halt_o, recover_we_o},
            {1'b1, 1'b1, 1'b0});
      tick();
      check("release", {recover_done_o, halt_o}, 64'd0);
      check("q_empty", 64'(q.size()), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout n_vec=%0d", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    n_vec       = 0;
    n_err       = 0;
    exp_cnt     = '0;
    rst_ni      = 1'b0;
    cmp_we_i    = 1'b0;
    cmp_addr_i  = '0;
    cmp_data_i  = '0;
    cmp_error_i = 1'b0;
    halt_ack_i  = 1'b0;
    for (int i = 0; i < 32; i++) m[i] = '0;
    repeat (3) tick();
    check("rst_out", {halt_o, recover_we_o, recover_addr_o,
                      recover_data_o, recover_done_o}, 64'd0);
`ifdef FT_ERR_CNT_EN
    check("rst_cnt", 64'(err_count_o), 64'd0);
`endif
    rst_ni = 1'b1;
    tick();

    agreed_wr(5'd5, 32'hDEADBEEF);
    agreed_wr(5'd31, 32'h12345678);
    run_recovery(3, 1'b0, 1'b0, 1'b0);

    agreed_wr(5'd0, 32'hFFFFFFFF);
    agreed_wr(5'd12, $urandom);
    run_recovery(1, 1'b0, 1'b0, 1'b0);

    run_recovery(0, 1'b1, 1'b0, 1'b0);

    agreed_wr(5'd3, 32'h0BADF00D);
    run_recovery(2, 1'b0, 1'b0, 1'b1);
    run_recovery(1, 1'b0, 1'b0, 1'b0);

    agreed_wr(5'd9, 32'h00000099);
    run_recovery(100, 1'b0, 1'b1, 1'b0);
    run_recovery(0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 2; k++) begin
      agreed_wr(5'(k + 20), $urandom);
      run_recovery(k + 1, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
